svc_rv_mem_model: RTL
=====================

// Module: svc_rv_mem_model
//
// PURPOSE
//   Parametrised memory responder for svc_rv formal and simulation harnesses. It serves as both the
//   instruction and the data memory model. Reads return stored words after a configurable LATENCY, and
//   byte-strobed writes update a small word array. Replaces fixed 0/1-cycle hand-coded imem/dmem timing
//   logic in harness wrappers.
//
// PARAMETERS
//   WORDS      32            storage depth in 32-bit words; power of two, >= 2
//   LATENCY    1             read latency in cycles, 0..4; 0 = combinational
//   IMMUTABLE  0             1 = write port ignored (instruction-memory use)
//   INIT_WORD  32'h00000013  value of every word and of the read pipeline after reset (NOP)
//
// PORTS
//   clock    in   1   single clock; all state on posedge
//   reset    in   1   asynchronous, active-high
//   arvalid  in   1   read request
//   arready  out  1   read request accepted when arvalid & arready
//   araddr   in   32  byte address; word index = araddr[AW+1:2], AW = $clog2(WORDS)
//   rvalid   out  1   read data valid
//   rdata    out  32  read data
//   we       in   1   write enable
//   waddr    in   32  byte address; same index rule as araddr
//   wdata    in   32  write data
//   wstrb    in   4   byte enables; wstrb[i] writes wdata[8i+7:8i]
//   stall    in   1   backpressure request; used only with SVC_RV_MEM_MODEL_STALL_EN
//
// BEHAVIOUR
//   - Reset (async assert, sync release):
//     - All words = INIT_WORD; rvalid = 0; rdata = 0; pipeline stages invalid with data INIT_WORD.
//     - arready = 1 (without STALL_EN) or !stall (with it).
//   - Addressing: address bits above AW+1 are ignored, so indices wrap modulo WORDS; bits [1:0] are ignored.
//   - Accept = arvalid & arready. Data is sampled from storage in the accept cycle. Later writes never alter
//     in-flight reads.
//   - LATENCY = 0: rvalid = accept and rdata = mem[idx] combinationally. rdata = 0 when !rvalid.
//   - LATENCY = N >= 1: N-stage shift of {valid,data}. rvalid = stage[N-1].valid.
//     - rdata = stage[N-1].data when rvalid, else 0.
//     - One accept per cycle; throughput 1/cycle; up to N reads in flight.
//   - Write: on posedge with we & !IMMUTABLE, mem[widx] bytes with wstrb set are updated.
//     - wstrb = 0 is a no-op. IMMUTABLE = 1 ignores all writes.
//   - Same-cycle read and write to the same index: the read returns the pre-write word (read-old).
//     A read accepted the next cycle sees the new word.
//   - Reset mid-operation: all in-flight reads are dropped (rvalid = 0 the same cycle, asynchronously) and
//     storage reverts to INIT_WORD.
//
// CONFIGURATION
//   SVC_RV_MEM_MODEL_STALL_EN defined:
//     - arready = !stall. While stall = 1 the read pipeline freezes: stages, rvalid and rdata hold their values.
//     - Writes are still performed while stall = 1.
//     - LATENCY = 0: stall forces arready = 0 and rvalid = 0.
//   SVC_RV_MEM_MODEL_STALL_EN undefined:
//     - stall is ignored; arready is constant 1; the pipeline always advances.
//
// STRUCTURE
//   - svc_rv_mem_model_pkg holds:
//     - MEM_XLEN = 32 and NOP_INSN = 32'h00000013;
//     - typedef rd_stage_t = struct {logic valid; logic [31:0] data};
//     - function merge_wstrb(old, wdata, wstrb).
//   - One sub-module, svc_rv_mem_model_pipe: a LATENCY-deep rd_stage_t shift register with an advance enable,
//     async-reset to invalid/INIT_WORD, and a generate bypass for LATENCY = 0.
//   - Storage, write merge and address decode stay in the top module.
//
// TESTING
//   1. LATENCY=1, after reset: arvalid=1 araddr=0x0 for 1 cycle
//      -> rvalid=1 with rdata=0x00000013 on the next cycle, and rvalid=0 the cycle after that.
//   2. LATENCY=3: reads of idx 0..3 on consecutive cycles after writes of 0xA0..0xA3
//      -> rvalid high 4 consecutive cycles starting 3 cycles after the first accept, with data
//         0xA0,0xA1,0xA2,0xA3 in order.
//   3. we=1 waddr=0x8 wdata=0xDEADBEEF wstrb=4'b0101 over word 0x11223344
//      -> a subsequent read of 0x8 returns 0x11AD33EF.
//   4. Same cycle: read 0x4 and write 0x4 = 0x55 -> that read returns the old word; a read on the next cycle
//      returns 0x55. With WORDS=32, araddr=0x84 aliases idx 1.
//   5. IMMUTABLE=1: write 0xFFFFFFFF to 0x0 -> a read of 0x0 still returns 0x00000013.
//   6. Reset asserted with 2 reads in flight (LATENCY=2) -> rvalid=0 immediately and after release;
//      written words read back 0x00000013.
//      With STALL_EN: stall=1 for 3 cycles mid-stream -> arready=0, rvalid/rdata held, no read lost or
//      duplicated.

Source files
------------

// File: rtl/svc_rv_mem_model_pkg.sv
// Shared types and helpers for the svc_rv memory responder.
package svc_rv_mem_model_pkg;

  localparam int          MEM_XLEN = 32;
  localparam logic [31:0] NOP_INSN = 32'h00000013;

  typedef struct packed {
    logic                valid;
    logic [MEM_XLEN-1:0] data;
  } rd_stage_t;

  function automatic logic [MEM_XLEN-1:0] merge_wstrb(
    input logic [MEM_XLEN-1:0] old,
    input logic [MEM_XLEN-1:0] wdata,
    input logic [3:0]          wstrb
  );
    logic [MEM_XLEN-1:0] res;
    res = old;
    for (int i = 0; i < 4; i++)
      if (wstrb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    return res;
  endfunction

endpackage

// File: rtl/svc_rv_mem_model_if.sv
// Read/write bus between a harness core (master) and the memory model (slave).
interface svc_rv_mem_model_if;
  import svc_rv_mem_model_pkg::*;

  logic                arvalid;
  logic                arready;
  logic [31:0]         araddr;
  logic                rvalid;
  logic [MEM_XLEN-1:0] rdata;
  logic                we;
  logic [31:0]         waddr;
  logic [MEM_XLEN-1:0] wdata;
  logic [3:0]          wstrb;
  logic                stall;

  modport master (
    output arvalid, araddr, we, waddr, wdata, wstrb, stall,
    input  arready, rvalid, rdata
  );

  modport slave (
    input  arvalid, araddr, we, waddr, wdata, wstrb, stall,
    output arready, rvalid, rdata
  );
endinterface

// File: rtl/svc_rv_mem_model_pipe.sv
// LATENCY-deep {valid,data} read shift register with advance enable; LATENCY=0 is a wire.
module svc_rv_mem_model_pipe
  import svc_rv_mem_model_pkg::*;
#(
  parameter int          LATENCY   = 1,
  parameter logic [31:0] INIT_WORD = NOP_INSN
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      adv,
  input  rd_stage_t din,
  output rd_stage_t dout
);

  generate
    if (LATENCY == 0) begin : g_bypass
      logic unused_ctl;
      assign unused_ctl = ^{clock, reset, adv};
      assign dout = din;
    end else begin : g_pipe
      rd_stage_t stg [LATENCY];

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < LATENCY; i++)
            stg[i] <= '{valid: 1'b0, data: INIT_WORD};
        end else if (adv) begin
          stg[0] <= din;
          for (int i = 1; i < LATENCY; i++)
            stg[i] <= stg[i-1];
        end
      end

      assign dout = stg[LATENCY-1];
    end
  endgenerate

endmodule

// File: rtl/svc_rv_mem_model.sv
// Parametrised imem/dmem responder: fixed-latency reads, byte-strobed writes.
// Optional backpressure via `define SVC_RV_MEM_MODEL_STALL_EN.
module svc_rv_mem_model
  import svc_rv_mem_model_pkg::*;
#(
  parameter int          WORDS     = 32,
  parameter int          LATENCY   = 1,
  parameter bit          IMMUTABLE = 1'b0,
  parameter logic [31:0] INIT_WORD = NOP_INSN
) (
  input logic               clock,
  input logic               reset,
  svc_rv_mem_model_if.slave bus
);

  localparam int AW = $clog2(WORDS);

  logic [MEM_XLEN-1:0] mem [WORDS];
  logic [AW-1:0]       ridx, widx;
  logic                accept, adv;
  rd_stage_t           din, dout;

`ifdef SVC_RV_MEM_MODEL_STALL_EN
  assign bus.arready = !bus.stall;
  assign adv         = !bus.stall;
`else
  logic unused_stall;
  assign unused_stall = bus.stall;
  assign bus.arready  = 1'b1;
  assign adv          = 1'b1;
`endif

  // Upper address bits alias, low two select a byte within the word.
  assign ridx = bus.araddr[AW+1:2];
  assign widx = bus.waddr[AW+1:2];

  logic unused_addr;
  assign unused_addr = ^{bus.araddr[31:AW+2], bus.araddr[1:0],
                         bus.waddr[31:AW+2], bus.waddr[1:0]};

  assign accept = bus.arvalid & bus.arready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= INIT_WORD;
    end else if (bus.we && !IMMUTABLE) begin
      mem[widx] <= merge_wstrb(mem[widx], bus.wdata, bus.wstrb);
    end
  end

  // Storage is sampled before the write lands, giving read-old on collisions.
  assign din = '{valid: accept, data: mem[ridx]};

  svc_rv_mem_model_pipe #(
    .LATENCY  (LATENCY),
    .INIT_WORD(INIT_WORD)
  ) u_pipe (
    .clock(clock),
    .reset(reset),
    .adv  (adv),
    .din  (din),
    .dout (dout)
  );

  assign bus.rvalid = dout.valid;
  assign bus.rdata  = dout.valid ? dout.data : '0;

endmodule
